// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake, presents Instr/PC/PC+8 to decode.
// Optional `FETCH_ALIGN_CHECK_EN forces branch targets word-aligned and raises a sticky AlignErr.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        Retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        AlignErr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        align_err_q, align_err_d;
  logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target = {Result[31:2], 2'b00};
`else
  assign target = Result;
`endif

  // Handshake: a word transfers on a rising edge where imem_req=1 and imem_ack=1;
  // imem_req stays high with imem_addr held until that edge, ack with req low is ignored.
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    align_err_d   = align_err_q;
    case (state_q)
      ST_RST: begin
        state_d       = ST_FETCH;
        imem_req_d    = 1'b1;
        instr_valid_d = 1'b0;
      end
      ST_FETCH: begin
        if (imem_req_q && imem_ack) begin
          instr_d       = imem_rdata;
          state_d       = ST_VALID;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
        end
      end
      ST_VALID: begin
        if (Retire) begin
          pc_d          = PCSrc ? target : pc_q + 32'd4;
          state_d       = ST_FETCH;
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (PCSrc && (Result[1:0] != 2'b00)) align_err_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d       = ST_RST;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RST;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      pc_q          <= RESET_PC;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      align_err_q   <= align_err_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign PC         = pc_q;
  assign PCPlus8    = pc_q + 32'd8;
  assign dbg_state  = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign AlignErr   = align_err_q;
`else
  assign AlignErr   = 1'b0;
`endif

endmodule
